// File: rtl/pc_control_unit.sv
// LEGv8 single-cycle fetch/decode: 64-bit program counter, next-PC selection and
// instruction decode into datapath control signals.
module pc_control_unit #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic        negative,
  input  logic        overflow,
  input  logic        zero,
  output logic [63:0] pc,
  output logic        Reg2Loc,
  output logic        ALUSrc,
  output logic        MemtoReg,
  output logic        RegWrite,
  output logic        MemWrite,
  output logic [2:0]  ALUOp,
  output logic        Imm,
  output logic        Brtaken,
  output logic        UncondBr,
  output logic        dir,
  output logic [1:0]  mush,
  output logic        wr
);

  logic [63:0] r_pc;
  logic [63:0] w_next_pc;
  logic [63:0] w_br_offset;
  logic [10:0] w_opcode;

  assign w_opcode = instruction[31:21];

  always_comb begin
    Reg2Loc  = 1'b0;
    ALUSrc   = 1'b0;
    MemtoReg = 1'b0;
    RegWrite = 1'b0;
    MemWrite = 1'b0;
    ALUOp    = 3'b000;
    Imm      = 1'b0;
    Brtaken  = 1'b0;
    UncondBr = 1'b0;
    dir      = 1'b0;
    mush     = 2'b00;
    wr       = 1'b0;
    casez (w_opcode)
      11'b1001000100?: begin // ADDI
        ALUSrc   = 1'b1;
        Imm      = 1'b1;
        RegWrite = 1'b1;
        ALUOp    = 3'b010;
      end
      11'b10101011000: begin // ADDS
        Reg2Loc  = 1'b1;
        RegWrite = 1'b1;
        wr       = 1'b1;
        ALUOp    = 3'b010;
      end
      11'b11101011000: begin // SUBS
        Reg2Loc  = 1'b1;
        RegWrite = 1'b1;
        wr       = 1'b1;
        ALUOp    = 3'b011;
      end
      11'b10001010000: begin // AND
        Reg2Loc  = 1'b1;
        RegWrite = 1'b1;
        ALUOp    = 3'b100;
      end
      11'b11001010000: begin // EOR
        Reg2Loc  = 1'b1;
        RegWrite = 1'b1;
        ALUOp    = 3'b110;
      end
      11'b11010011011: begin // LSL
        RegWrite = 1'b1;
        mush     = 2'b01;
      end
      11'b11010011010: begin // LSR
        RegWrite = 1'b1;
        mush     = 2'b01;
        dir      = 1'b1;
      end
      11'b11111000010: begin // LDUR
        ALUSrc   = 1'b1;
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
        ALUOp    = 3'b010;
      end
      11'b11111000000: begin // STUR
        ALUSrc   = 1'b1;
        MemWrite = 1'b1;
        ALUOp    = 3'b010;
      end
      11'b000101?????: begin // B
        UncondBr = 1'b1;
        Brtaken  = 1'b1;
      end
      11'b10110100???: Brtaken = zero; // CBZ
      // B.cond: only LT is supported, using the registered N/V flags
      11'b01010100???: Brtaken = (instruction[4:0] == 5'b01011) & (negative ^ overflow);
      default: ;
    endcase
  end

  assign w_br_offset = UncondBr ? {{36{instruction[25]}}, instruction[25:0], 2'b00}
                                : {{43{instruction[23]}}, instruction[23:5], 2'b00};
  assign w_next_pc   = Brtaken ? r_pc + w_br_offset : r_pc + 64'd4;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_next_pc;
    end
  end

  assign pc = r_pc;

endmodule

// File: tb/tb_pc_control_unit.sv
// Self-checking bench for pc_control_unit: reset behaviour, decode table, branch
// corner cases and randomized instructions against a behavioural model.
module tb_pc_control_unit;

  logic        clk;
  logic        reset;
  logic [31:0] instruction;
  logic        negative, overflow, zero;
  logic [63:0] pc;
  logic        Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemWrite, Imm, Brtaken, UncondBr, dir, wr;
  logic [2:0]  ALUOp;
  logic [1:0]  mush;
  logic [14:0] w_ctrl;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  logic [63:0] exp_pc;

  pc_control_unit dut (
    .clk        (clk),
    .reset      (reset),
    .instruction(instruction),
    .negative   (negative),
    .overflow   (overflow),
    .zero       (zero),
    .pc         (pc),
    .Reg2Loc    (Reg2Loc),
    .ALUSrc     (ALUSrc),
    .MemtoReg   (MemtoReg),
    .RegWrite   (RegWrite),
    .MemWrite   (MemWrite),
    .ALUOp      (ALUOp),
    .Imm        (Imm),
    .Brtaken    (Brtaken),
    .UncondBr   (UncondBr),
    .dir        (dir),
    .mush       (mush),
    .wr         (wr)
  );

  assign w_ctrl = {Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemWrite, ALUOp, Imm, Brtaken,
                   UncondBr, dir, mush, wr};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed control word; bit 5 is Brtaken, bit 4 is UncondBr
  function automatic logic [14:0] mk(input logic r2l, input logic als, input logic m2r,
                                     input logic rw, input logic mw, input logic [2:0] aop,
                                     input logic imm, input logic br, input logic ub,
                                     input logic dr, input logic [1:0] ms, input logic fw);
    return {r2l, als, m2r, rw, mw, aop, imm, br, ub, dr, ms, fw};
  endfunction

  // Reference decode: classify the instruction by mnemonic, then list its controls
  function automatic logic [14:0] ref_ctrl(input logic [31:0] ins, input logic n,
                                           input logic v, input logic z);
    logic [10:0] op;
    op = ins[31:21];
    if (ins[31:22] == 10'b1001000100) return mk(0, 1, 0, 1, 0, 3'd2, 1, 0, 0, 0, 2'd0, 0);
    if (op == 11'b10101011000)        return mk(1, 0, 0, 1, 0, 3'd2, 0, 0, 0, 0, 2'd0, 1);
    if (op == 11'b11101011000)        return mk(1, 0, 0, 1, 0, 3'd3, 0, 0, 0, 0, 2'd0, 1);
    if (op == 11'b10001010000)        return mk(1, 0, 0, 1, 0, 3'd4, 0, 0, 0, 0, 2'd0, 0);
    if (op == 11'b11001010000)        return mk(1, 0, 0, 1, 0, 3'd6, 0, 0, 0, 0, 2'd0, 0);
    if (op == 11'b11010011011)        return mk(0, 0, 0, 1, 0, 3'd0, 0, 0, 0, 0, 2'd1, 0);
    if (op == 11'b11010011010)        return mk(0, 0, 0, 1, 0, 3'd0, 0, 0, 0, 1, 2'd1, 0);
    if (op == 11'b11111000010)        return mk(0, 1, 1, 1, 0, 3'd2, 0, 0, 0, 0, 2'd0, 0);
    if (op == 11'b11111000000)        return mk(0, 1, 0, 0, 1, 3'd2, 0, 0, 0, 0, 2'd0, 0);
    if (ins[31:26] == 6'b000101)      return mk(0, 0, 0, 0, 0, 3'd0, 0, 1, 1, 0, 2'd0, 0);
    if (ins[31:24] == 8'b10110100)    return mk(0, 0, 0, 0, 0, 3'd0, 0, z, 0, 0, 2'd0, 0);
    if (ins[31:24] == 8'b01010100)
      return mk(0, 0, 0, 0, 0, 3'd0, 0, (ins[4:0] == 5'b01011) && (n != v), 0, 0, 2'd0, 0);
    return 15'd0;
  endfunction

  function automatic logic [63:0] ref_next(input logic [63:0] p, input logic [31:0] ins,
                                           input logic [14:0] c);
    longint off;
    if (!c[5]) return p + 64'd4;
    if (c[4]) off = longint'($signed(ins[25:0]));
    else      off = longint'($signed(ins[23:5]));
    return p + 64'(off * 4);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Entered just after a rising edge; leaves just after the next one
  task automatic apply(input logic [31:0] ins, input logic n, input logic v, input logic z,
                       input logic [14:0] exp_ctrl, input logic [63:0] exp_next,
                       input string name);
    instruction = ins;
    negative    = n;
    overflow    = v;
    zero        = z;
    #4;
    chk({name, "_ctrl"}, 64'(w_ctrl), 64'(exp_ctrl));
    @(posedge clk);
    #1;
    chk({name, "_pc"}, pc, exp_next);
    exp_pc = exp_next;
  endtask

  task automatic goto_pc(input logic [63:0] target);
    logic [63:0] d;
    d = target - exp_pc;
    apply({6'b000101, d[27:2]}, 0, 0, 0, mk(0, 0, 0, 0, 0, 3'd0, 0, 1, 1, 0, 2'd0, 0),
          target, "goto");
  endtask

  typedef struct {
    logic [31:0] instr;
    logic        n;
    logic        v;
    logic        z;
    logic [14:0] ctrl;
    string       name;
  } vec_t;

  vec_t tbl[12];

  initial begin
    logic [31:0] ins, r;
    logic        n, v, z;
    logic [14:0] c;

    tbl[0]  = '{32'h910017E1, 0, 0, 0, mk(0, 1, 0, 1, 0, 3'd2, 1, 0, 0, 0, 2'd0, 0), "addi"};
    tbl[1]  = '{{11'b11101011000, 5'd2, 6'd0, 5'd1, 5'd3}, 0, 0, 0,
                mk(1, 0, 0, 1, 0, 3'd3, 0, 0, 0, 0, 2'd0, 1), "subs"};
    tbl[2]  = '{{11'b10101011000, 5'd2, 6'd0, 5'd1, 5'd3}, 1, 0, 1,
                mk(1, 0, 0, 1, 0, 3'd2, 0, 0, 0, 0, 2'd0, 1), "adds"};
    tbl[3]  = '{{11'b10001010000, 21'h1234}, 0, 0, 0,
                mk(1, 0, 0, 1, 0, 3'd4, 0, 0, 0, 0, 2'd0, 0), "and"};
    tbl[4]  = '{{11'b11001010000, 21'h0F0F}, 0, 0, 0,
                mk(1, 0, 0, 1, 0, 3'd6, 0, 0, 0, 0, 2'd0, 0), "eor"};
    tbl[5]  = '{{11'b11010011011, 21'h00C41}, 0, 0, 0,
                mk(0, 0, 0, 1, 0, 3'd0, 0, 0, 0, 0, 2'd1, 0), "lsl"};
    tbl[6]  = '{{11'b11010011010, 21'h00C41}, 0, 0, 0,
                mk(0, 0, 0, 1, 0, 3'd0, 0, 0, 0, 1, 2'd1, 0), "lsr"};
    tbl[7]  = '{{11'b11111000010, 21'h00822}, 0, 0, 0,
                mk(0, 1, 1, 1, 0, 3'd2, 0, 0, 0, 0, 2'd0, 0), "ldur"};
    tbl[8]  = '{{11'b11111000000, 21'h00822}, 0, 0, 1,
                mk(0, 1, 0, 0, 1, 3'd2, 0, 0, 0, 0, 2'd0, 0), "stur"};
    tbl[9]  = '{32'h0, 1, 0, 1, 15'd0, "nop"};
    tbl[10] = '{{8'b01010100, 19'd2, 5'b00000}, 1, 0, 0, 15'd0, "bcond_eq"};
    tbl[11] = '{{8'b10110100, 19'd3, 5'd1}, 0, 0, 0, 15'd0, "cbz_nz"};

    // Reset held low with the clock running, then released
    reset = 1'b0;
    instruction = 32'h0;
    negative = 1'b0;
    overflow = 1'b0;
    zero = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_hold", pc, 64'h0);
    chk("reset_ctrl", 64'(w_ctrl), 64'h0);
    reset = 1'b1;
    #2;
    chk("release_pc", pc, 64'h0);
    @(posedge clk);
    #1;
    chk("first_step", pc, 64'h4);
    @(posedge clk);
    #1;
    chk("second_step", pc, 64'h8);
    // Asynchronous assertion between edges
    #2;
    reset = 1'b0;
    #1;
    chk("async_reset", pc, 64'h0);
    @(posedge clk);
    #1;
    chk("reset_held", pc, 64'h0);
    reset = 1'b1;
    exp_pc = 64'h0;

    for (int i = 0; i < 12; i++) begin
      apply(tbl[i].instr, tbl[i].n, tbl[i].v, tbl[i].z, tbl[i].ctrl, exp_pc + 64'd4,
            tbl[i].name);
    end

    // Branch corner cases at fixed addresses
    goto_pc(64'h10);
    apply({6'b000101, 26'h3FFFFFE}, 0, 0, 0, mk(0, 0, 0, 0, 0, 3'd0, 0, 1, 1, 0, 2'd0, 0),
          64'h08, "b_back");
    goto_pc(64'h20);
    apply({8'b10110100, 19'd3, 5'd0}, 0, 0, 1, mk(0, 0, 0, 0, 0, 3'd0, 0, 1, 0, 0, 2'd0, 0),
          64'h2C, "cbz_taken");
    goto_pc(64'h20);
    apply({8'b10110100, 19'd3, 5'd0}, 0, 0, 0, 15'd0, 64'h24, "cbz_not");
    goto_pc(64'h40);
    apply({8'b01010100, 19'd2, 5'b01011}, 1, 0, 0,
          mk(0, 0, 0, 0, 0, 3'd0, 0, 1, 0, 0, 2'd0, 0), 64'h48, "blt_taken");
    goto_pc(64'h40);
    apply({8'b01010100, 19'd2, 5'b01011}, 1, 1, 0, 15'd0, 64'h44, "blt_not");
    goto_pc(64'h40);
    apply({8'b01010100, 19'd2, 5'b00001}, 1, 0, 1, 15'd0, 64'h44, "bne_ignored");
    // Wrap below zero
    goto_pc(64'h0);
    apply({6'b000101, 26'h3FFFFFF}, 0, 0, 0, mk(0, 0, 0, 0, 0, 3'd0, 0, 1, 1, 0, 2'd0, 0),
          64'hFFFF_FFFF_FFFF_FFFC, "b_wrap");

    for (int i = 0; i < 300; i++) begin
      r = $urandom;
      case ($urandom_range(0, 12))
        0:  ins = {10'b1001000100, r[21:0]};
        1:  ins = {11'b10101011000, r[20:0]};
        2:  ins = {11'b11101011000, r[20:0]};
        3:  ins = {11'b10001010000, r[20:0]};
        4:  ins = {11'b11001010000, r[20:0]};
        5:  ins = {11'b11010011011, r[20:0]};
        6:  ins = {11'b11010011010, r[20:0]};
        7:  ins = {11'b11111000010, r[20:0]};
        8:  ins = {11'b11111000000, r[20:0]};
        9:  ins = {6'b000101, r[25:0]};
        10: ins = {8'b10110100, r[23:0]};
        11: ins = {8'b01010100, r[23:5], ($urandom_range(0, 1) == 1) ? 5'b01011 : r[4:0]};
        default: ins = r;
      endcase
      n = 1'($urandom_range(0, 1));
      v = 1'($urandom_range(0, 1));
      z = 1'($urandom_range(0, 1));
      c = ref_ctrl(ins, n, v, z);
      apply(ins, n, v, z, c, ref_next(exp_pc, ins, c), "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
